// File: rtl/decomp_sequencer.sv
// Control sequencer for a compressed-instruction decompressor: fetches a word,
// expands token opcodes into two table words. Optional counters: DECOMP_STATS_EN.
module decomp_sequencer #(
  parameter int                    WIDTH      = 32,
  parameter int                    ENCODE_LEN = 4,
  parameter logic [ENCODE_LEN-1:0] OPCODE     = 4'b1111
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_pc_change,
  input  logic                  i_branch,
  input  logic [ENCODE_LEN-1:0] i_opcode,
  output logic                  o_pc_sel,
  output logic                  o_pc_en,
  output logic                  o_in_en,
  output logic                  o_ipc_en,
  output logic                  o_tbl_sel,
  output logic                  o_out_sel,
  output logic                  o_out1_en,
  output logic                  o_out2_en,
  output logic                  o_stall,
  output logic                  o_out_valid,
  output logic [WIDTH-1:0]      o_tok_cnt,
  output logic [WIDTH-1:0]      o_ins_cnt,
  output logic [2:0]            o_state
);

  // CPU handshake: i_pc_change is a request that is only accepted in IDLE and
  // EXP2; while o_stall is high the CPU holds its PC and requests are ignored.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REDIR  = 3'd1,
    S_FETCH  = 3'd2,
    S_DECODE = 3'd3,
    S_EXP2   = 3'd4
  } state_t;

  state_t r_state;
  logic   r_pc_sel;
  logic   r_pc_en;
  logic   r_in_en;
  logic   r_ipc_en;
  logic   r_tbl_sel;
  logic   r_out_sel;
  logic   r_out1_en;
  logic   r_out2_en;
  logic   r_stall;
  logic   r_out_valid;
  logic   w_encode;

  assign w_encode = (i_opcode == OPCODE);

  // Outputs are registered with the state they belong to, so each strobe is
  // visible during the cycle after the decision that produced it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_pc_sel    <= 1'b0;
      r_pc_en     <= 1'b0;
      r_in_en     <= 1'b0;
      r_ipc_en    <= 1'b0;
      r_tbl_sel   <= 1'b0;
      r_out_sel   <= 1'b0;
      r_out1_en   <= 1'b0;
      r_out2_en   <= 1'b0;
      r_stall     <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_pc_sel    <= 1'b0;
      r_pc_en     <= 1'b0;
      r_in_en     <= 1'b0;
      r_ipc_en    <= 1'b0;
      r_tbl_sel   <= 1'b0;
      r_out_sel   <= 1'b0;
      r_out1_en   <= 1'b0;
      r_out2_en   <= 1'b0;
      r_stall     <= 1'b0;
      r_out_valid <= r_out1_en;
      case (r_state)
        S_IDLE: begin
          if (i_pc_change) begin
            if (i_branch) begin
              r_state  <= S_REDIR;
              r_pc_sel <= 1'b1;
              r_pc_en  <= 1'b1;
              r_stall  <= 1'b1;
            end else begin
              r_state  <= S_FETCH;
              r_pc_en  <= 1'b1;
              r_in_en  <= 1'b1;
              r_ipc_en <= 1'b1;
              r_stall  <= 1'b1;
            end
          end
        end
        S_REDIR: begin
          r_state  <= S_FETCH;
          r_pc_en  <= 1'b1;
          r_in_en  <= 1'b1;
          r_ipc_en <= 1'b1;
          r_stall  <= 1'b1;
        end
        S_FETCH: begin
          r_state <= S_DECODE;
          r_stall <= 1'b1;
        end
        S_DECODE: begin
          r_tbl_sel <= w_encode;
          r_out1_en <= 1'b1;
          r_out2_en <= w_encode;
          r_state   <= w_encode ? S_EXP2 : S_IDLE;
        end
        S_EXP2: begin
          if (i_pc_change) begin
            if (i_branch) begin
              // Taken branch abandons the pending second token word.
              r_state  <= S_REDIR;
              r_pc_sel <= 1'b1;
              r_pc_en  <= 1'b1;
              r_stall  <= 1'b1;
            end else begin
              r_state   <= S_IDLE;
              r_out_sel <= 1'b1;
              r_out1_en <= 1'b1;
              r_ipc_en  <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef DECOMP_STATS_EN
  logic [WIDTH-1:0] r_tok_cnt;
  logic [WIDTH-1:0] r_ins_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tok_cnt <= '0;
      r_ins_cnt <= '0;
    end else begin
      if (r_state == S_DECODE && w_encode) r_tok_cnt <= r_tok_cnt + 1'b1;
      if (r_out1_en)                       r_ins_cnt <= r_ins_cnt + 1'b1;
    end
  end

  assign o_tok_cnt = r_tok_cnt;
  assign o_ins_cnt = r_ins_cnt;
`else
  assign o_tok_cnt = '0;
  assign o_ins_cnt = '0;
`endif

  assign o_pc_sel    = r_pc_sel;
  assign o_pc_en     = r_pc_en;
  assign o_in_en     = r_in_en;
  assign o_ipc_en    = r_ipc_en;
  assign o_tbl_sel   = r_tbl_sel;
  assign o_out_sel   = r_out_sel;
  assign o_out1_en   = r_out1_en;
  assign o_out2_en   = r_out2_en;
  assign o_stall     = r_stall;
  assign o_out_valid = r_out_valid;
  assign o_state     = r_state;

endmodule

// File: tb/tb_decomp_sequencer.sv
// Directed bench for decomp_sequencer: per-cycle output patterns plus a
// scoreboard of delivered words keyed by the cycle their out1_en must appear.
module tb_decomp_sequencer;

`ifdef DECOMP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // Output pattern bit order: pc_sel pc_en in_en ipc_en tbl_sel out_sel out1_en out2_en stall out_valid
  localparam logic [9:0] P_IDLE   = 10'b0000000000;
  localparam logic [9:0] P_REDIR  = 10'b1100000010;
  localparam logic [9:0] P_FETCH  = 10'b0111000010;
  localparam logic [9:0] P_DECODE = 10'b0000000010;
  localparam logic [9:0] P_WORD1  = 10'b0000001000;
  localparam logic [9:0] P_TOKEN  = 10'b0000101100;
  localparam logic [9:0] P_WORD2  = 10'b0001011000;
  localparam logic [9:0] P_VALID  = 10'b0000000001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pc_change = 1'b0;
  logic        branch = 1'b0;
  logic [3:0]  opcode = 4'h0;
  logic        o_pc_sel, o_pc_en, o_in_en, o_ipc_en, o_tbl_sel, o_out_sel;
  logic        o_out1_en, o_out2_en, o_stall, o_out_valid;
  logic [31:0] o_tok_cnt, o_ins_cnt;
  logic [2:0]  o_state;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [18:0] exp_q[$];
  logic [31:0] exp_tok = '0;
  logic [31:0] exp_ins = '0;
  logic        prev_o1 = 1'b0;
  logic        prev_rst = 1'b1;

  decomp_sequencer dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_pc_change (pc_change),
    .i_branch    (branch),
    .i_opcode    (opcode),
    .o_pc_sel    (o_pc_sel),
    .o_pc_en     (o_pc_en),
    .o_in_en     (o_in_en),
    .o_ipc_en    (o_ipc_en),
    .o_tbl_sel   (o_tbl_sel),
    .o_out_sel   (o_out_sel),
    .o_out1_en   (o_out1_en),
    .o_out2_en   (o_out2_en),
    .o_stall     (o_stall),
    .o_out_valid (o_out_valid),
    .o_tok_cnt   (o_tok_cnt),
    .o_ins_cnt   (o_ins_cnt),
    .o_state     (o_state)
  );

  // Clock / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] outs();
    return {o_pc_sel, o_pc_en, o_in_en, o_ipc_en, o_tbl_sel, o_out_sel,
            o_out1_en, o_out2_en, o_stall, o_out_valid};
  endfunction

  // Driver: apply inputs for one cycle, return just after the sampling edge.
  task automatic drive(input logic pc, input logic br, input logic [3:0] op);
    pc_change = pc;
    branch    = br;
    opcode    = op;
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input int lat, input logic tbl, input logic os, input logic o2);
    logic [15:0] c;
    c = 16'(cyc + lat);
    exp_q.push_back({c, tbl, os, o2});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 4'h0);
    drive(1'b0, 1'b0, 4'h0);
    reset = 1'b0;
    exp_tok = '0;
    exp_ins = '0;
  endtask

  task automatic chk_state(input string tag, input logic [9:0] pat, input logic [2:0] st);
    chk({tag, "_outs"}, 32'(outs()), 32'(pat));
    chk({tag, "_state"}, 32'(o_state), 32'(st));
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_tok"}, o_tok_cnt, STATS ? exp_tok : 32'd0);
    chk({tag, "_ins"}, o_ins_cnt, STATS ? exp_ins : 32'd0);
  endtask

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    chk("out_valid_copy", 32'(o_out_valid), 32'(prev_o1 & ~prev_rst));
    if (o_out1_en === 1'b1) begin
      chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0)
        chk("sb_word", 32'({cyc[15:0], o_tbl_sel, o_out_sel, o_out2_en}), 32'(exp_q.pop_front()));
    end
    prev_o1  = o_out1_en;
    prev_rst = reset;
  end

  initial begin
    // Reset state
    drive(1'b0, 1'b0, 4'h0);
    drive(1'b0, 1'b0, 4'h0);
    chk_state("reset", P_IDLE, 3'd0);
    chk_cnt("reset");
    reset = 1'b0;
    drive(1'b0, 1'b0, 4'h0);
    chk_state("idle_hold", P_IDLE, 3'd0);

    // Sequential fetch of a raw word; pc_change held high while stalled
    push_word(3, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'h3);
    chk_state("seq_fetch", P_FETCH, 3'd2);
    drive(1'b1, 1'b0, 4'h3);
    chk_state("seq_decode", P_DECODE, 3'd3);
    drive(1'b1, 1'b0, 4'h3);
    chk_state("seq_word1", P_WORD1, 3'd0);
    drive(1'b0, 1'b0, 4'h0);
    chk_state("seq_valid", P_VALID, 3'd0);
    exp_ins = exp_ins + 1;
    chk_cnt("seq");

    // Branch redirect then raw word
    push_word(4, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 4'h2);
    chk_state("br_redir", P_REDIR, 3'd1);
    drive(1'b1, 1'b1, 4'h2);
    chk_state("br_fetch", P_FETCH, 3'd2);
    drive(1'b0, 1'b0, 4'h2);
    chk_state("br_decode", P_DECODE, 3'd3);
    drive(1'b0, 1'b0, 4'h2);
    chk_state("br_word1", P_WORD1, 3'd0);
    drive(1'b0, 1'b0, 4'h0);
    chk_state("br_valid", P_VALID, 3'd0);
    exp_ins = exp_ins + 1;
    chk_cnt("br");

    // Token expansion, second word after a 3-cycle gap in EXP2
    do_reset();
    push_word(3, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 4'hF);
    drive(1'b0, 1'b0, 4'hF);
    chk_state("tok_decode", P_DECODE, 3'd3);
    drive(1'b0, 1'b0, 4'hF);
    chk_state("tok_word1", P_TOKEN, 3'd4);
    exp_tok = exp_tok + 1;
    chk_cnt("tok_w1");
    drive(1'b0, 1'b0, 4'h0);
    chk_state("tok_gap1", P_VALID, 3'd4);
    exp_ins = exp_ins + 1;
    drive(1'b0, 1'b0, 4'h0);
    chk_state("tok_gap2", P_IDLE, 3'd4);
    drive(1'b0, 1'b0, 4'h0);
    push_word(1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 4'h0);
    chk_state("tok_word2", P_WORD2, 3'd0);
    drive(1'b0, 1'b0, 4'h0);
    chk_state("tok_valid2", P_VALID, 3'd0);
    exp_ins = exp_ins + 1;
    chk_cnt("tok_w2");

    // Token interrupted by a taken branch in EXP2
    do_reset();
    push_word(3, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 4'hF);
    drive(1'b0, 1'b0, 4'hF);
    drive(1'b0, 1'b0, 4'hF);
    exp_tok = exp_tok + 1;
    chk_state("tbr_word1", P_TOKEN, 3'd4);
    drive(1'b0, 1'b0, 4'h0);
    exp_ins = exp_ins + 1;
    push_word(4, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 4'h3);
    chk_state("tbr_redir", P_REDIR, 3'd1);
    chk_cnt("tbr_redir");
    drive(1'b0, 1'b0, 4'h3);
    drive(1'b0, 1'b0, 4'h3);
    drive(1'b0, 1'b0, 4'h3);
    chk_state("tbr_word1b", P_WORD1, 3'd0);
    drive(1'b0, 1'b0, 4'h0);
    exp_ins = exp_ins + 1;
    chk_cnt("tbr_end");

    // Reset while in DECODE with a token opcode
    drive(1'b1, 1'b0, 4'hF);
    drive(1'b0, 1'b0, 4'hF);
    chk_state("rst_decode", P_DECODE, 3'd3);
    reset = 1'b1;
    drive(1'b0, 1'b0, 4'hF);
    exp_tok = '0;
    exp_ins = '0;
    chk_state("rst_hit", P_IDLE, 3'd0);
    chk_cnt("rst_hit");
    reset = 1'b0;
    drive(1'b0, 1'b0, 4'h0);
    chk_state("rst_after", P_IDLE, 3'd0);

    // Instruction counter wrap
`ifdef DECOMP_STATS_EN
    dut.r_ins_cnt <= '1;
    #1;
    exp_ins = '1;
    chk_cnt("wrap_pre");
`endif
    push_word(3, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'h5);
    drive(1'b0, 1'b0, 4'h5);
    drive(1'b0, 1'b0, 4'h5);
    drive(1'b0, 1'b0, 4'h0);
    exp_ins = exp_ins + 1;
    chk("wrap_ins_zero", o_ins_cnt, 32'd0);
    chk_cnt("wrap_post");
    drive(1'b0, 1'b0, 4'h0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
